exec_seq_ctrl: RTL and testbench

- Multicycle sequencer for the RV32I core; drives the ALU operand-A select (PC vs RS1), the operand-B select, and the PC, IR, register-file and memory strobes.
- Sits between instruction decode and the datapath.
- Owns the core-wide fetch/decode/execute/memory/writeback state machine.
- One instruction is in flight at a time; memory accesses use a req/ready handshake.

---
 rtl/exec_seq_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_exec_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_seq_ctrl.sv
// Purpose: multicycle fetch/decode/execute/memory/writeback sequencer for the RV32I core.
// Latency: 4 cycles per ALU/jump/branch/store instruction and 5 per load, plus memory wait cycles.
// Backpressure: FETCH and MEM hold mem_req until mem_ready; every other state ignores mem_ready.
//
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   run               start enable (used only when RESET_TO_FETCH=0)
//   opcode            instr[6:0], sampled in DECODE
//   branch_taken      comparator result, sampled in EXEC for branches
//   mem_ready         memory handshake completion
//   ctrl_RS1, alu_b_sel, alu_pass_b          ALU operand controls
//   ir_we, pc_we, pc_inc, reg_we, wb_sel     datapath strobes
//   mem_req, mem_we, addr_sel                memory request controls
//   trap, state_o, instret                   status / debug
//
// Optional macro EXEC_SEQ_INSTRET_EN: when defined, instret counts retired
// instructions; otherwise instret is tied to zero.
module exec_seq_ctrl #(
  parameter bit RESET_TO_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        ctrl_RS1,
  output logic [1:0]  alu_b_sel,
  output logic        alu_pass_b,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_inc,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        trap,
  output logic [2:0]  state_o,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRTGT  = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE   = 4'd0,
    C_LUI    = 4'd1,
    C_AUIPC  = 4'd2,
    C_JAL    = 4'd3,
    C_JALR   = 4'd4,
    C_BRANCH = 4'd5,
    C_LOAD   = 4'd6,
    C_STORE  = 4'd7,
    C_OPIMM  = 4'd8,
    C_OP     = 4'd9
  } cls_t;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  state_t state_q, state_d;
  cls_t   class_q, class_d;
  logic   taken_q, taken_d;
  cls_t   dec_class;

  always_comb begin
    dec_class = C_NONE;
    case (opcode)
      7'b0110111: dec_class = C_LUI;
      7'b0010111: dec_class = C_AUIPC;
      7'b1101111: dec_class = C_JAL;
      7'b1100111: dec_class = C_JALR;
      7'b1100011: dec_class = C_BRANCH;
      7'b0000011: dec_class = C_LOAD;
      7'b0100011: dec_class = C_STORE;
      7'b0010011: dec_class = C_OPIMM;
      7'b0110011: dec_class = C_OP;
      default:    dec_class = C_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      class_q <= C_NONE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    taken_d    = taken_q;
    ctrl_RS1   = 1'b0;
    alu_b_sel  = B_RS2;
    alu_pass_b = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_inc     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RESET_TO_FETCH || run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        // IR captures the returned word in the completing cycle.
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        state_d = (dec_class == C_NONE) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (class_q)
          C_OP:    begin ctrl_RS1 = 1'b1; alu_b_sel = B_RS2; end
          C_OPIMM: begin ctrl_RS1 = 1'b1; alu_b_sel = B_IMM; end
          C_LUI:   begin alu_b_sel = B_IMM; alu_pass_b = 1'b1; end
          C_AUIPC: begin alu_b_sel = B_IMM; end
          C_LOAD, C_STORE: begin
            ctrl_RS1  = 1'b1;
            alu_b_sel = B_IMM;
            state_d   = S_MEM;
          end
          C_JAL:   begin alu_b_sel = B_IMM; pc_we = 1'b1; end
          C_JALR:  begin ctrl_RS1 = 1'b1; alu_b_sel = B_IMM; pc_we = 1'b1; end
          C_BRANCH: begin
            ctrl_RS1  = 1'b1;
            alu_b_sel = B_RS2;
            taken_d   = branch_taken;
            state_d   = S_BRTGT;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_BRTGT: begin
        // ALU now forms PC+imm; PC takes it only if the compare said taken.
        alu_b_sel = B_IMM;
        pc_we     = taken_q;
        pc_inc    = ~taken_q;
        state_d   = S_FETCH;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (class_q == C_STORE);
        if (mem_ready) begin
          if (class_q == C_STORE) begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        if (class_q == C_LOAD)                           wb_sel = WB_MEM;
        else if (class_q == C_JAL || class_q == C_JALR)  wb_sel = WB_PC4;
        else                                             wb_sel = WB_ALU;
        // Jumps already loaded PC in EXEC.
        pc_inc  = ~(class_q == C_JAL || class_q == C_JALR);
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;

`ifdef EXEC_SEQ_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = (state_q == S_WB) || (state_q == S_BRTGT) ||
                  ((state_q == S_MEM) && (class_q == C_STORE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= 32'h0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_exec_seq_ctrl.sv
module tb_exec_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        ctrl_RS1;
  logic [1:0]  alu_b_sel;
  logic        alu_pass_b;
  logic        ir_we;
  logic        pc_we;
  logic        pc_inc;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        trap;
  logic [2:0]  state_o;
  logic [31:0] instret;

  exec_seq_ctrl #(.RESET_TO_FETCH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .ctrl_RS1(ctrl_RS1), .alu_b_sel(alu_b_sel), .alu_pass_b(alu_pass_b),
    .ir_we(ir_we), .pc_we(pc_we), .pc_inc(pc_inc), .reg_we(reg_we),
    .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .trap(trap), .state_o(state_o), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] outs;
    logic [31:0] ir;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    exp_ir = 0;

  // {state, ctrl_RS1, alu_b_sel, alu_pass_b, ir_we, pc_we, pc_inc, reg_we, wb_sel, mem_req, mem_we, addr_sel, trap}
  function automatic logic [16:0] mk(logic [2:0] st, logic rs1, logic [1:0] bs, logic pb,
                                     logic irw, logic pcw, logic pci, logic rgw, logic [1:0] wbs,
                                     logic mrq, logic mw, logic as, logic tr);
    return {st, rs1, bs, pb, irw, pcw, pci, rgw, wbs, mrq, mw, as, tr};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during it.
  task automatic cyc(input string tag, input logic rst, input logic [6:0] op,
                     input logic br, input logic mr, input logic [16:0] e, input logic ret);
    exp_t x;
    rst_n        = rst;
    opcode       = op;
    branch_taken = br;
    mem_ready    = mr;
    if (!rst) exp_ir = 0;
    x.outs = e;
`ifdef EXEC_SEQ_INSTRET_EN
    x.ir = 32'(exp_ir);
`else
    x.ir = 32'h0;
`endif
    exp_q.push_back(x);
    tag_q.push_back(tag);
    if (ret) exp_ir = exp_ir + 1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  x;
      string t;
      logic [16:0] act;
      x   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {state_o, ctrl_RS1, alu_b_sel, alu_pass_b, ir_we, pc_we, pc_inc, reg_we,
             wb_sel, mem_req, mem_we, addr_sel, trap};
      n_cmp = n_cmp + 1;
      if (act !== x.outs) begin
        n_fail = n_fail + 1;
        $display("FAIL %s outs: got %b required %b", t, act, x.outs);
      end
      n_cmp = n_cmp + 1;
      if (instret !== x.ir) begin
        n_fail = n_fail + 1;
        $display("FAIL %s instret: got %0d required %0d", t, instret, x.ir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic [16:0] v_idle, v_fetch, v_fwait, v_dec, v_trap;
  logic [16:0] v_alu_wb, v_load_mem, v_st_wait, v_st_done;

  initial begin
    v_idle     = mk(3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    v_fetch    = mk(3'd1, 0, 2'd0, 0, 1, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    v_fwait    = mk(3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    v_dec      = mk(3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    v_trap     = mk(3'd7, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1);
    v_alu_wb   = mk(3'd5, 0, 2'd0, 0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0);
    v_load_mem = mk(3'd4, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0);
    v_st_wait  = mk(3'd4, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 1, 0);
    v_st_done  = mk(3'd4, 0, 2'd0, 0, 0, 0, 1, 0, 2'd0, 1, 1, 1, 0);

    rst_n = 1'b0; run = 1'b0; opcode = 7'h0; branch_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cyc("reset",       0, 7'h00, 0, 1, v_idle, 0);
    cyc("idle",        1, 7'h00, 0, 1, v_idle, 0);
    // ADDI
    cyc("addi_fetch",  1, 7'h00, 0, 1, v_fetch, 0);
    cyc("addi_dec",    1, 7'b0010011, 0, 1, v_dec, 0);
    cyc("addi_exec",   1, 7'b0010011, 0, 1, mk(3'd3, 1, 2'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("addi_wb",     1, 7'b0010011, 0, 1, v_alu_wb, 1);
    // AUIPC
    cyc("auipc_fetch", 1, 7'h00, 0, 1, v_fetch, 0);
    cyc("auipc_dec",   1, 7'b0010111, 0, 1, v_dec, 0);
    cyc("auipc_exec",  1, 7'b0010111, 0, 1, mk(3'd3, 0, 2'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("auipc_wb",    1, 7'b0010111, 0, 1, v_alu_wb, 1);
    // JAL
    cyc("jal_fetch",   1, 7'h00, 0, 1, v_fetch, 0);
    cyc("jal_dec",     1, 7'b1101111, 0, 1, v_dec, 0);
    cyc("jal_exec",    1, 7'b1101111, 0, 1, mk(3'd3, 0, 2'd1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("jal_wb",      1, 7'b1101111, 0, 1, mk(3'd5, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0), 1);
    // JALR
    cyc("jalr_fetch",  1, 7'h00, 0, 1, v_fetch, 0);
    cyc("jalr_dec",    1, 7'b1100111, 0, 1, v_dec, 0);
    cyc("jalr_exec",   1, 7'b1100111, 0, 1, mk(3'd3, 1, 2'd1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("jalr_wb",     1, 7'b1100111, 0, 1, mk(3'd5, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0), 1);
    // LUI
    cyc("lui_fetch",   1, 7'h00, 0, 1, v_fetch, 0);
    cyc("lui_dec",     1, 7'b0110111, 0, 1, v_dec, 0);
    cyc("lui_exec",    1, 7'b0110111, 0, 1, mk(3'd3, 0, 2'd1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("lui_wb",      1, 7'b0110111, 0, 1, v_alu_wb, 1);
    // OP, with one fetch wait cycle
    cyc("op_fwait",    1, 7'h00, 0, 0, v_fwait, 0);
    cyc("op_fetch",    1, 7'h00, 0, 1, v_fetch, 0);
    cyc("op_dec",      1, 7'b0110011, 0, 1, v_dec, 0);
    cyc("op_exec",     1, 7'b0110011, 0, 1, mk(3'd3, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("op_wb",       1, 7'b0110011, 0, 1, v_alu_wb, 1);
    // BRANCH taken; branch_taken dropped in BRTGT must not matter
    cyc("brt_fetch",   1, 7'h00, 0, 1, v_fetch, 0);
    cyc("brt_dec",     1, 7'b1100011, 0, 1, v_dec, 0);
    cyc("brt_exec",    1, 7'b1100011, 1, 1, mk(3'd3, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("brt_tgt",     1, 7'b1100011, 0, 1, mk(3'd6, 0, 2'd1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0), 1);
    // BRANCH not taken
    cyc("brn_fetch",   1, 7'h00, 0, 1, v_fetch, 0);
    cyc("brn_dec",     1, 7'b1100011, 0, 1, v_dec, 0);
    cyc("brn_exec",    1, 7'b1100011, 0, 1, mk(3'd3, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("brn_tgt",     1, 7'b1100011, 1, 1, mk(3'd6, 0, 2'd1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0), 1);
    // LOAD with three memory wait cycles
    cyc("ld_fetch",    1, 7'h00, 0, 1, v_fetch, 0);
    cyc("ld_dec",      1, 7'b0000011, 0, 1, v_dec, 0);
    cyc("ld_exec",     1, 7'b0000011, 0, 0, mk(3'd3, 1, 2'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    for (int i = 0; i < 3; i++)
      cyc("ld_memwait", 1, 7'b0000011, 0, 0, v_load_mem, 0);
    cyc("ld_memdone",  1, 7'b0000011, 0, 1, v_load_mem, 0);
    cyc("ld_wb",       1, 7'b0000011, 0, 1, mk(3'd5, 0, 2'd0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 0), 1);
    // STORE with one memory wait cycle; retires from MEM
    cyc("st_fetch",    1, 7'h00, 0, 1, v_fetch, 0);
    cyc("st_dec",      1, 7'b0100011, 0, 1, v_dec, 0);
    cyc("st_exec",     1, 7'b0100011, 0, 1, mk(3'd3, 1, 2'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0), 0);
    cyc("st_memwait",  1, 7'b0100011, 0, 0, v_st_wait, 0);
    cyc("st_memdone",  1, 7'b0100011, 0, 1, v_st_done, 1);
    // Illegal opcode -> sticky trap, mem_ready toggling ignored
    cyc("ill_fetch",   1, 7'h00, 0, 1, v_fetch, 0);
    cyc("ill_dec",     1, 7'h7F, 0, 1, v_dec, 0);
    for (int i = 0; i < 12; i++)
      cyc("trap_hold", 1, 7'h7F, 0, 1'(i % 2), v_trap, 0);
    cyc("trap_reset",  0, 7'h00, 0, 1, v_idle, 0);
    cyc("post_idle",   1, 7'h00, 0, 0, v_idle, 0);
    // Reset pulsed during a fetch wait abandons the access
    cyc("rf_wait0",    1, 7'h00, 0, 0, v_fwait, 0);
    cyc("rf_wait1",    1, 7'h00, 0, 0, v_fwait, 0);
    cyc("rf_reset",    0, 7'h00, 0, 0, v_idle, 0);
    cyc("rf_idle",     1, 7'h00, 0, 1, v_idle, 0);
    cyc("rf_wait2",    1, 7'h00, 0, 0, v_fwait, 0);
    cyc("rf_fetch",    1, 7'h00, 0, 1, v_fetch, 0);
    cyc("rf_dec",      1, 7'b0010011, 0, 1, v_dec, 0);

    @(negedge clk);
    #1;
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
